// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for a BCD frequency counter: clear, one-second gate, latch, display hold.
// Latency: every output is registered, so each output follows the FSM decision one cycle later.
// Backpressure: none; run=0 parks the sequencer in IDLE and a debounced key press restarts the sequence.
module freq_meas_ctrl #(
  parameter int CLK_FRE  = 12_000_000,
  parameter int HOLD_SEC = 2,
  parameter int DEB_CYC  = 240_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       key_n,
  output logic [3:0] sel,
  output logic       cnt_clr,
  output logic       gate_en,
  output logic       latch,
  output logic       valid,
  output logic       busy
);

  // Timer terminal values: the timer restarts at 0 on entry, so the last cycle is N-1.
  localparam logic [31:0] GATE_LAST = 32'(CLK_FRE - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_SEC * CLK_FRE - 1);
  localparam logic [19:0] DEB_LAST  = 20'(DEB_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    GATE  = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] timer;

  logic        key_meta;
  logic        key_sync;
  logic        key_stable;   // debounced level, 1 = released
  logic [19:0] deb_cnt;
  logic        key_evt;

  // Two-flop synchronizer for the asynchronous push-button; rests at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Debounce: count consecutive cycles that disagree with the stable level; any agreeing cycle restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_stable <= 1'b1;
      deb_cnt    <= '0;
    end else if (key_sync != key_stable) begin
      if (deb_cnt == DEB_LAST) begin
        key_stable <= key_sync;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // A press fires on the cycle the low level completes its stability run, once per press.
  assign key_evt = key_stable && !key_sync && (deb_cnt == DEB_LAST);

  // Next-state selection with priority run=0, key press, then timer expiry.
  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = IDLE;
    end else if (key_evt) begin
      state_nxt = (state == IDLE) ? IDLE : CLEAR;
    end else begin
      case (state)
        IDLE:    state_nxt = CLEAR;
        CLEAR:   state_nxt = GATE;
        GATE:    if (timer == GATE_LAST) state_nxt = LATCH;
        LATCH:   state_nxt = HOLD;
        HOLD:    if (timer == HOLD_LAST) state_nxt = CLEAR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and per-state timer; the timer restarts on any entry, including a CLEAR re-entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || key_evt) begin
        timer <= '0;
      end else if (timer != 32'hFFFF_FFFF) begin
        timer <= timer + 32'd1;
      end
    end
  end

  // Registered outputs decoded from the next state, plus source select and result-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      cnt_clr <= 1'b0;
      gate_en <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      cnt_clr <= (state_nxt == CLEAR);
      gate_en <= (state_nxt == GATE);
      latch   <= (state_nxt == LATCH);
      busy    <= (state_nxt == CLEAR) || (state_nxt == GATE) || (state_nxt == LATCH);
      if (key_evt) begin
        sel <= sel + 4'd1;
      end
      // A new source or a fresh clear invalidates the display; a completed latch validates it.
      if (key_evt) begin
        valid <= 1'b0;
      end else if (run && (state == LATCH)) begin
        valid <= 1'b1;
      end else if (state_nxt == CLEAR) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl with small timing parameters.
// Directed scenarios followed by randomized run/key/reset stimulus.
// Every cycle is compared against a phase-position reference model.
module tb_freq_meas_ctrl;

  localparam int CLK_FRE  = 10;
  localparam int HOLD_SEC = 2;
  localparam int DEB_CYC  = 4;
  localparam int GATE_N   = CLK_FRE;
  localparam int PERIOD   = 1 + CLK_FRE + 1 + HOLD_SEC * CLK_FRE;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       key_n;
  logic [3:0] sel;
  logic       cnt_clr;
  logic       gate_en;
  logic       latch;
  logic       valid;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position inside one measurement period, idle flag, key history.
  bit               m_idle  = 1'b1;
  int               m_pos   = 0;
  logic [3:0]       m_sel   = 4'd0;
  bit               m_valid = 1'b0;
  bit               kd0     = 1'b1;
  bit               kd1     = 1'b1;
  logic [DEB_CYC-1:0] win   = '1;
  bit               armed   = 1'b1;

  freq_meas_ctrl #(
    .CLK_FRE (CLK_FRE),
    .HOLD_SEC(HOLD_SEC),
    .DEB_CYC (DEB_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .key_n  (key_n),
    .sel    (sel),
    .cnt_clr(cnt_clr),
    .gate_en(gate_en),
    .latch  (latch),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit ks;
    bit evt;
    if (rst) begin
      m_idle = 1'b1; m_pos = 0; m_sel = 4'd0; m_valid = 1'b0;
      kd0 = 1'b1; kd1 = 1'b1; win = '1; armed = 1'b1;
    end else begin
      ks  = kd1;
      kd1 = kd0;
      kd0 = key_n;
      win = {win[DEB_CYC-2:0], ks};
      evt = armed && (win == '0);
      if (evt) armed = 1'b0;
      else if (!armed && (win == '1)) armed = 1'b1;
      if (evt) begin
        m_sel   = m_sel + 4'd1;
        m_valid = 1'b0;
      end
      if (!run) begin
        m_idle = 1'b1;
      end else if (evt) begin
        if (!m_idle) m_pos = 0;
      end else if (m_idle) begin
        m_idle = 1'b0; m_pos = 0; m_valid = 1'b0;
      end else begin
        if (m_pos == GATE_N + 1) m_valid = 1'b1;
        m_pos = (m_pos + 1) % PERIOD;
        if (m_pos == 0) m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("sel",     32'(sel),     32'(m_sel));
    chk("cnt_clr", 32'(cnt_clr), 32'(!m_idle && m_pos == 0));
    chk("gate_en", 32'(gate_en), 32'(!m_idle && m_pos >= 1 && m_pos <= GATE_N));
    chk("latch",   32'(latch),   32'(!m_idle && m_pos == GATE_N + 1));
    chk("busy",    32'(busy),    32'(!m_idle && m_pos <= GATE_N + 1));
    chk("valid",   32'(valid),   32'(m_valid));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold_key(input logic v, input int n);
    key_n = v;
    repeat (n) step();
  endtask

  // Step until the model sits at the given period position; an expired budget is a failure.
  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (!(!m_idle && m_pos == p) && n < 200) begin
      step();
      n++;
    end
    chk("wait_pos_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; key_n = 1'b1;
    #1;
    repeat (3) step();
    chk("rst_sel",   32'(sel),     32'd0);
    chk("rst_clr",   32'(cnt_clr), 32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_valid", 32'(valid),   32'd0);

    // Scenario 1: free-running measurement loop, three full periods.
    run = 1'b1; rst = 1'b0;
    step();
    chk("s1_first_clr", 32'(cnt_clr), 32'd1);
    repeat (3 * PERIOD + 2) step();

    // Scenario 2: bouncy long press gives one increment; a short press gives none.
    hold_key(1'b0, 1); hold_key(1'b1, 1); hold_key(1'b0, 1);
    hold_key(1'b0, 20);
    hold_key(1'b1, 1); hold_key(1'b0, 1); hold_key(1'b1, 1);
    hold_key(1'b1, 10);
    chk("s2_sel_bounce", 32'(sel), 32'd1);
    hold_key(1'b0, 3);
    hold_key(1'b1, 10);
    chk("s2_sel_short", 32'(sel), 32'd1);

    // Scenario 3: sixteen clean presses walk sel through the full range.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      hold_key(1'b0, 8);
      hold_key(1'b1, 8);
      chk("s3_sel", 32'(sel), 32'(i % 16));
    end

    // Scenario 4: press fires in gate cycle 5, then on the last gate cycle.
    wait_pos(0);
    hold_key(1'b0, 8);
    hold_key(1'b1, 4);
    chk("s4_sel_mid", 32'(sel), 32'd1);
    repeat (PERIOD + 8) step();
    wait_pos(GATE_N - DEB_CYC - 1);
    hold_key(1'b0, 8);
    hold_key(1'b1, 4);
    chk("s4_sel_last", 32'(sel), 32'd2);
    repeat (PERIOD + 8) step();

    // Scenario 5: run dropped in hold keeps valid; reset inside the gate clears everything.
    wait_pos(GATE_N + 5);
    run = 1'b0;
    step();
    chk("s5_valid_kept", 32'(valid), 32'd1);
    chk("s5_idle_busy",  32'(busy),  32'd0);
    repeat (3) step();
    run = 1'b1;
    step();
    chk("s5_restart_clr", 32'(cnt_clr), 32'd1);
    wait_pos(3);
    rst = 1'b1;
    step();
    chk("s5_rst_gate",  32'(gate_en), 32'd0);
    chk("s5_rst_latch", 32'(latch),   32'd0);
    chk("s5_rst_sel",   32'(sel),     32'd0);
    chk("s5_rst_valid", 32'(valid),   32'd0);
    rst = 1'b0;

    // Randomized run / key / reset activity against the model.
    for (int s = 0; s < 600; s++) begin
      key_n = 1'($urandom_range(0, 1));
      run   = ($urandom_range(0, 15) != 0);
      rst   = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
        step();
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
